// File: rtl/dragon_pkg.sv
// Shared dragon sprite constants: segment word layout, orientations, defaults.
// Imported by the body chain and the head controller.
package dragon_pkg;
  localparam int SEG_W            = 10;
  localparam int ORIENT_W         = 2;
  localparam int POS_W            = SEG_W - ORIENT_W;
  localparam int DEF_MAX_SEGMENTS = 8;
  localparam int DEF_MOVE_PERIOD  = 10;

  typedef enum logic [ORIENT_W-1:0] {UP = 2'd0, RIGHT = 2'd1, DOWN = 2'd2, LEFT = 2'd3} orient_e;

  // Low n bits set; callers truncate to their own slot count.
  function automatic logic [15:0] therm16(input logic [4:0] n);
    logic [15:0] t;
    t = '0;
    for (int i = 0; i < 16; i++) t[i] = (5'(i) < n);
    return t;
  endfunction
endpackage

// File: rtl/frame_tick_gen.sv
// vsync rising-edge detector plus modulo-MOVE_PERIOD frame counter.
// shift is combinational and high for the clk on which the wrapping edge is seen.
module frame_tick_gen
  import dragon_pkg::*;
#(
  parameter int MOVE_PERIOD = DEF_MOVE_PERIOD
) (
  input  logic clk,
  input  logic reset,
  input  logic vsync,
  output logic shift
);
  logic       r_prev_vsync;
  logic [5:0] r_frame_cnt;
  logic       w_frame_edge;
  logic       w_wrap;

  assign w_frame_edge = vsync & ~r_prev_vsync;
  assign w_wrap       = (r_frame_cnt == 6'(MOVE_PERIOD - 1));
  assign shift        = w_frame_edge & w_wrap;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_prev_vsync <= 1'b0;
      r_frame_cnt  <= '0;
    end else begin
      r_prev_vsync <= vsync;
      if (w_frame_edge) r_frame_cnt <= w_wrap ? 6'd0 : r_frame_cnt + 6'd1;
    end
  end
endmodule

// File: rtl/dragon_body_chain.sv
// Dragon body queue: shifts the head into a segment chain every MOVE_PERIOD
// frames, tracks live length, drives per-slot enables and head/body collision.
module dragon_body_chain #(
  parameter int MAX_SEGMENTS = dragon_pkg::DEF_MAX_SEGMENTS,
  parameter int SEG_W        = dragon_pkg::SEG_W,
  parameter int MOVE_PERIOD  = dragon_pkg::DEF_MOVE_PERIOD,
  parameter int INIT_LENGTH  = 0
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            vsync,
  input  logic                            heal,
  input  logic                            hit,
  input  logic [SEG_W-1:0]                dragon_head,
  output logic [MAX_SEGMENTS*SEG_W-1:0]   segments,
  output logic [MAX_SEGMENTS-1:0]         display_en,
  output logic [$clog2(MAX_SEGMENTS+1)-1:0] length,
  output logic                            move_tick,
  output logic                            self_collision,
  output logic                            empty_hit
);
  import dragon_pkg::*;

  localparam int LW = $clog2(MAX_SEGMENTS + 1);
  localparam int PW = SEG_W - ORIENT_W;
  localparam logic [MAX_SEGMENTS-1:0] INIT_DISP = MAX_SEGMENTS'(therm16(5'(INIT_LENGTH)));

  logic [MAX_SEGMENTS-1:0][SEG_W-1:0] r_seg;
  logic [LW-1:0]                      r_len;
  logic [MAX_SEGMENTS-1:0]            r_disp;
  logic                               r_move_tick;
  logic                               r_collision;
  logic                               r_empty_hit;

  logic                    w_shift;
  logic [LW-1:0]           w_len_nxt;
  logic [MAX_SEGMENTS-1:0] w_disp_nxt;
  logic                    w_empty_hit;
  logic                    w_collision;

  frame_tick_gen #(.MOVE_PERIOD(MOVE_PERIOD)) u_tick (
    .clk   (clk),
    .reset (reset),
    .vsync (vsync),
    .shift (w_shift)
  );

  // Simultaneous heal and hit cancel out.
  always_comb begin
    w_len_nxt   = r_len;
    w_empty_hit = 1'b0;
    if (heal && !hit) begin
      if (r_len != LW'(MAX_SEGMENTS)) w_len_nxt = r_len + 1'b1;
    end else if (hit && !heal) begin
      if (r_len == '0) w_empty_hit = 1'b1;
      else             w_len_nxt   = r_len - 1'b1;
    end
    w_disp_nxt = MAX_SEGMENTS'(therm16(5'(w_len_nxt)));
  end

  // Slot 0 is skipped: it mirrors the head right after every shift.
  always_comb begin
    w_collision = 1'b0;
    for (int i = 1; i < MAX_SEGMENTS; i++)
      if (r_disp[i] && (r_seg[i][PW-1:0] == dragon_head[PW-1:0])) w_collision = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_seg       <= '0;
      r_len       <= LW'(INIT_LENGTH);
      r_disp      <= INIT_DISP;
      r_move_tick <= 1'b0;
      r_collision <= 1'b0;
      r_empty_hit <= 1'b0;
    end else begin
      r_move_tick <= w_shift;
      if (w_shift) begin
        r_seg[0] <= dragon_head;
        for (int i = 1; i < MAX_SEGMENTS; i++) r_seg[i] <= r_seg[i-1];
      end
      r_len       <= w_len_nxt;
      r_disp      <= w_disp_nxt;
      r_empty_hit <= w_empty_hit;
      r_collision <= w_collision;
    end
  end

  assign segments       = r_seg;
  assign display_en     = r_disp;
  assign length         = r_len;
  assign move_tick      = r_move_tick;
  assign self_collision = r_collision;
  assign empty_hit      = r_empty_hit;
endmodule

// File: tb/tb_dragon_body_chain.sv
// Self-checking bench for dragon_body_chain: directed scenarios plus a random
// run checked against a queue-based behavioural model.
module tb_dragon_body_chain;
  localparam int MAXS = 8;
  localparam int SW   = 10;
  localparam int MP   = 10;
  localparam int INIT = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            vsync = 1'b0;
  logic            heal = 1'b0;
  logic            hit = 1'b0;
  logic [SW-1:0]   dragon_head = '0;
  logic [MAXS*SW-1:0] segments;
  logic [MAXS-1:0] display_en;
  logic [3:0]      length;
  logic            move_tick;
  logic            self_collision;
  logic            empty_hit;

  int checks = 0;
  int errors = 0;

  // behavioural model state
  logic [SW-1:0] mq[$];
  int m_len = INIT;
  int m_cnt = 0;
  bit m_pv = 0, m_tick = 0, m_col = 0, m_eh = 0;

  dragon_body_chain #(.MAX_SEGMENTS(MAXS), .SEG_W(SW), .MOVE_PERIOD(MP), .INIT_LENGTH(INIT)) dut (
    .clk(clk), .reset(reset), .vsync(vsync), .heal(heal), .hit(hit),
    .dragon_head(dragon_head), .segments(segments), .display_en(display_en),
    .length(length), .move_tick(move_tick), .self_collision(self_collision),
    .empty_hit(empty_hit)
  );

  always #5 clk = ~clk;

  function automatic logic [MAXS*SW-1:0] m_segs();
    logic [MAXS*SW-1:0] v;
    v = '0;
    for (int i = 0; i < MAXS; i++) v[i*SW +: SW] = mq[i];
    return v;
  endfunction

  function automatic logic [MAXS-1:0] m_disp();
    logic [MAXS-1:0] v;
    v = '0;
    for (int i = 0; i < MAXS; i++) v[i] = (i < m_len);
    return v;
  endfunction

  // One clock: advance the model from the inputs held across the edge, then settle.
  task automatic tick();
    bit col, sh;
    @(posedge clk);
    if (!reset) begin
      mq = {};
      repeat (MAXS) mq.push_back('0);
      m_len = INIT; m_cnt = 0; m_pv = 0; m_tick = 0; m_col = 0; m_eh = 0;
    end else begin
      col = 0;
      for (int i = 1; i < MAXS; i++)
        if (i < m_len && mq[i][SW-3:0] == dragon_head[SW-3:0]) col = 1;
      sh = 0;
      if (vsync && !m_pv) begin
        if (m_cnt == MP - 1) begin m_cnt = 0; sh = 1; end
        else m_cnt++;
      end
      m_pv = vsync;
      m_tick = sh;
      if (sh) begin mq.push_front(dragon_head); void'(mq.pop_back()); end
      m_eh = 0;
      if (heal && !hit) begin if (m_len < MAXS) m_len++; end
      else if (hit && !heal) begin if (m_len == 0) m_eh = 1; else m_len--; end
      m_col = col;
    end
    #1;
  endtask

  task automatic edge_pulse(inout int n);
    vsync = 1'b1; tick(); n += int'(move_tick);
    vsync = 1'b0; tick(); n += int'(move_tick);
  endtask

  task automatic do_shift(input logic [SW-1:0] h);
    int n;
    n = 0;
    dragon_head = h;
    repeat (MP) edge_pulse(n);
    checks++;
    if (n !== 1) begin errors++; $display("FAIL shift_count head=%h: got %0d exp 1", h, n); end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(); tick();
    checks++; if (segments !== '0) begin errors++; $display("FAIL reset_segments: got %h exp 0", segments); end
    checks++; if (length !== 4'd2) begin errors++; $display("FAIL reset_length: got %0d exp 2", length); end
    checks++; if (display_en !== 8'b00000011) begin errors++; $display("FAIL reset_display_en: got %b exp 00000011", display_en); end
    checks++; if ({move_tick, self_collision, empty_hit} !== 3'b000) begin errors++; $display("FAIL reset_pulses: got %b exp 000", {move_tick, self_collision, empty_hit}); end
    reset = 1'b1;
  endtask

  task automatic test_shift();
    int n;
    logic [SW-1:0] prior;
    n = 0;
    dragon_head = 10'h123;
    repeat (9) edge_pulse(n);
    checks++; if (n !== 0) begin errors++; $display("FAIL nine_edges_no_shift: got %0d ticks exp 0", n); end
    prior = mq[0];
    edge_pulse(n);
    checks++; if (n !== 1) begin errors++; $display("FAIL tenth_edge_shift: got %0d ticks exp 1", n); end
    checks++; if (segments[SW-1:0] !== 10'h123) begin errors++; $display("FAIL shift_slot0: got %h exp 123", segments[SW-1:0]); end
    checks++; if (segments[2*SW-1:SW] !== prior) begin errors++; $display("FAIL shift_slot1: got %h exp %h", segments[2*SW-1:SW], prior); end
    checks++; if (segments !== m_segs()) begin errors++; $display("FAIL shift_chain: got %h exp %h", segments, m_segs()); end
  endtask

  task automatic test_length();
    int eh_cnt;
    bit last_eh;
    while (m_len > 0) begin hit = 1; tick(); hit = 0; tick(); end
    repeat (9) begin heal = 1; tick(); heal = 0; tick(); end
    checks++; if (length !== 4'd8) begin errors++; $display("FAIL heal_saturate: got %0d exp 8", length); end
    checks++; if (display_en !== 8'hFF) begin errors++; $display("FAIL heal_display_en: got %b exp 11111111", display_en); end
    eh_cnt = 0; last_eh = 0;
    for (int k = 0; k < 9; k++) begin
      hit = 1; tick(); eh_cnt += int'(empty_hit); last_eh = empty_hit;
      hit = 0; tick(); eh_cnt += int'(empty_hit);
    end
    checks++; if (length !== 4'd0) begin errors++; $display("FAIL hit_floor: got %0d exp 0", length); end
    checks++; if (eh_cnt !== 1) begin errors++; $display("FAIL empty_hit_count: got %0d exp 1", eh_cnt); end
    checks++; if (last_eh !== 1'b1) begin errors++; $display("FAIL empty_hit_on_ninth: got %b exp 1", last_eh); end
  endtask

  task automatic test_both();
    repeat (3) begin heal = 1; tick(); heal = 0; tick(); end
    heal = 1; hit = 1; tick();
    heal = 0; hit = 0;
    checks++; if (length !== 4'd3) begin errors++; $display("FAIL both_length: got %0d exp 3", length); end
    checks++; if (display_en !== 8'b00000111) begin errors++; $display("FAIL both_display_en: got %b exp 00000111", display_en); end
    checks++; if (empty_hit !== 1'b0) begin errors++; $display("FAIL both_empty_hit: got %b exp 0", empty_hit); end
  endtask

  task automatic test_collision();
    heal = 1; tick(); heal = 0; tick();
    do_shift(10'h145); do_shift(10'h0AA); do_shift(10'h0BB);
    dragon_head = 10'h245; tick();
    checks++; if (self_collision !== 1'b1) begin errors++; $display("FAIL collide_slot2: got %b exp 1", self_collision); end
    do_shift(10'h0C1); do_shift(10'h0C2); do_shift(10'h0C3);
    dragon_head = 10'h245; tick();
    checks++; if (self_collision !== 1'b0) begin errors++; $display("FAIL collide_hidden_slot5: got %b exp 0", self_collision); end
    do_shift(10'h045);
    dragon_head = 10'h345; tick();
    checks++; if (self_collision !== 1'b0) begin errors++; $display("FAIL collide_slot0: got %b exp 0", self_collision); end
    checks++; if (segments !== m_segs()) begin errors++; $display("FAIL collide_chain: got %h exp %h", segments, m_segs()); end
  endtask

  task automatic test_reset_mid();
    int n;
    n = 0;
    dragon_head = 10'h077;
    repeat (7) edge_pulse(n);
    reset = 0; tick(); reset = 1;
    checks++; if (length !== 4'd2) begin errors++; $display("FAIL mid_reset_length: got %0d exp 2", length); end
    n = 0;
    repeat (9) edge_pulse(n);
    checks++; if (n !== 0) begin errors++; $display("FAIL mid_reset_nine_edges: got %0d ticks exp 0", n); end
    edge_pulse(n);
    checks++; if (n !== 1) begin errors++; $display("FAIL mid_reset_tenth_edge: got %0d ticks exp 1", n); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 3) == 0) vsync = ~vsync;
      heal = ($urandom_range(0, 5) == 0);
      hit  = ($urandom_range(0, 5) == 0);
      dragon_head = {2'($urandom_range(0, 3)), 8'(8'h10 + $urandom_range(0, 3))};
      tick();
      checks++;
      if ({segments, display_en, length, move_tick, self_collision, empty_hit} !==
          {m_segs(), m_disp(), 4'(m_len), m_tick, m_col, m_eh}) begin
        errors++;
        if (errors < 20)
          $display("FAIL random_cycle%0d: got seg=%h en=%b len=%0d mt=%b col=%b eh=%b exp seg=%h en=%b len=%0d mt=%b col=%b eh=%b",
                   c, segments, display_en, length, move_tick, self_collision, empty_hit,
                   m_segs(), m_disp(), m_len, m_tick, m_col, m_eh);
      end
    end
    vsync = 0; heal = 0; hit = 0;
  endtask

  initial begin
    repeat (MAXS) mq.push_back('0);
    test_reset();
    test_shift();
    test_length();
    test_both();
    test_collision();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
